// File: rtl/nic_vc_flits_buffer_pkg.sv
// Shared types and sizing helpers for the NIC virtual-channel flit buffer.
package nic_vc_flits_buffer_pkg;

  // Flit type lives in the top FLIT_TYPE_BITS bits of every flit.
  localparam int FLIT_TYPE_BITS = 2;

  typedef enum logic [1:0] {
    FT_HEAD      = 2'b00,
    FT_BODY      = 2'b01,
    FT_TAIL      = 2'b10,
    FT_HEAD_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    VC_IDLE      = 2'b00,
    VC_RECEIVING = 2'b01,
    VC_READY     = 2'b10
  } vc_state_e;

  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int vc_bits_f(input int n_vc);
    return (n_vc > 1) ? clog2_f(n_vc) : 1;
  endfunction

endpackage

// File: rtl/nic_vc_flits_buffer_slot.sv
// One virtual channel: packet assembly FSM, flit count and slot storage.
module nic_vc_slot
  import nic_vc_flits_buffer_pkg::*;
#(
  parameter int FLIT_WIDTH  = 32,
  parameter int MAX_PKT_LEN = 8,
  parameter int LEN_BITS    = clog2_f(MAX_PKT_LEN + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flit_valid,
  input  flit_type_e                        flit_type,
  input  logic [FLIT_WIDTH-1:0]             flit_data,
  input  logic                              accept,
  output logic                              ready,
  output logic [LEN_BITS-1:0]               count,
  output logic [MAX_PKT_LEN*FLIT_WIDTH-1:0] slots,
  output logic                              err_pulse
);

  vc_state_e                                 state_r;
  vc_state_e                                 state_s;
  logic                                      store_s;
  logic                                      clear_s;
  logic                                      err_s;
  logic                                      last_body_s;
  logic [LEN_BITS-1:0]                       count_r;
  logic [MAX_PKT_LEN-1:0][FLIT_WIDTH-1:0]    slots_r;

  // A BODY arriving here would leave no slot for the TAIL.
  assign last_body_s = (count_r == LEN_BITS'(MAX_PKT_LEN - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= VC_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      VC_IDLE: begin
        if (flit_valid) begin
          case (flit_type)
            FT_HEAD:      state_s = VC_RECEIVING;
            FT_HEAD_TAIL: state_s = VC_READY;
            default:      state_s = VC_IDLE;
          endcase
        end else begin
          state_s = VC_IDLE;
        end
      end
      VC_RECEIVING: begin
        if (flit_valid) begin
          case (flit_type)
            FT_BODY: state_s = last_body_s ? VC_IDLE : VC_RECEIVING;
            FT_TAIL: state_s = VC_READY;
            default: state_s = VC_IDLE;
          endcase
        end else begin
          state_s = VC_RECEIVING;
        end
      end
      VC_READY: begin
        if (accept) begin
          state_s = VC_IDLE;
        end else begin
          state_s = VC_READY;
        end
      end
      default: state_s = VC_IDLE;
    endcase
  end

  // Store / discard / error controls for the current flit.
  always_comb begin
    store_s = 1'b0;
    clear_s = 1'b0;
    err_s   = 1'b0;
    case (state_r)
      VC_IDLE: begin
        if (flit_valid) begin
          if (flit_type == FT_HEAD || flit_type == FT_HEAD_TAIL) begin
            store_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          store_s = 1'b0;
        end
      end
      VC_RECEIVING: begin
        if (flit_valid) begin
          case (flit_type)
            FT_BODY: begin
              if (last_body_s) begin
                clear_s = 1'b1;
                err_s   = 1'b1;
              end else begin
                store_s = 1'b1;
              end
            end
            FT_TAIL: store_s = 1'b1;
            default: begin
              clear_s = 1'b1;
              err_s   = 1'b1;
            end
          endcase
        end else begin
          store_s = 1'b0;
        end
      end
      VC_READY: begin
        err_s   = flit_valid;
        clear_s = accept;
      end
      default: clear_s = 1'b1;
    endcase
  end

  // Count and slot storage; a clear always wins over a store.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {LEN_BITS{1'b0}};
      slots_r <= '0;
    end else if (clear_s) begin
      count_r <= {LEN_BITS{1'b0}};
      slots_r <= '0;
    end else if (store_s) begin
      count_r <= count_r + LEN_BITS'(1);
      for (int i = 0; i < MAX_PKT_LEN; i++) begin
        if (count_r == LEN_BITS'(i)) begin
          slots_r[i] <= flit_data;
        end
      end
    end else begin
      count_r <= count_r;
    end
  end

  assign ready     = (state_r == VC_READY);
  assign count     = count_r;
  assign slots     = slots_r;
  assign err_pulse = err_s;

endmodule

// File: rtl/nic_vc_flits_buffer.sv
// Router-side receive buffer: per-VC packet assembly, round-robin offer with lock.
module nic_vc_flits_buffer
  import nic_vc_flits_buffer_pkg::*;
#(
  parameter int FLIT_WIDTH  = 32,
  parameter int N_VC        = 2,
  parameter int MAX_PKT_LEN = 8,
  parameter int VC_BITS     = vc_bits_f(N_VC),
  parameter int LEN_BITS    = clog2_f(MAX_PKT_LEN + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [FLIT_WIDTH-1:0]             in_link_i,
  input  logic                              in_valid_i,
  input  logic [VC_BITS-1:0]                in_vc_i,
  output logic [N_VC-1:0]                   credit_o,
  output logic [N_VC-1:0]                   free_o,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [VC_BITS-1:0]                out_vc_o,
  output logic [LEN_BITS-1:0]               out_len_o,
  output logic [MAX_PKT_LEN*FLIT_WIDTH-1:0] out_link_o,
  output logic                              err_o
);

  flit_type_e                         in_type_s;
  logic                               vc_ok_s;
  logic [N_VC-1:0]                    slot_valid_s;
  logic [N_VC-1:0]                    slot_accept_s;
  logic [N_VC-1:0]                    vc_ready_s;
  logic [N_VC-1:0]                    vc_err_s;
  logic [LEN_BITS-1:0]                vc_count_s [N_VC];
  logic [MAX_PKT_LEN*FLIT_WIDTH-1:0]  vc_slots_s [N_VC];
  logic                               found_s;
  logic                               accept_s;
  logic [VC_BITS-1:0]                 sel_s;
  logic [VC_BITS-1:0]                 next_ptr_s;
  logic [LEN_BITS-1:0]                out_len_s;
  logic [MAX_PKT_LEN*FLIT_WIDTH-1:0]  out_link_s;
  logic [VC_BITS-1:0]                 rr_ptr_r;
  logic                               lock_r;
  logic [VC_BITS-1:0]                 lock_vc_r;
  logic                               err_r;

  assign in_type_s = flit_type_e'(in_link_i[FLIT_WIDTH-1 -: FLIT_TYPE_BITS]);

  // Out-of-range VC indices only exist when N_VC is not a power of two.
  if ((1 << VC_BITS) == N_VC) begin : g_vc_full
    assign vc_ok_s = 1'b1;
  end else begin : g_vc_partial
    assign vc_ok_s = (in_vc_i < VC_BITS'(N_VC));
  end

  for (genvar v = 0; v < N_VC; v++) begin : g_vc
    nic_vc_slot #(
      .FLIT_WIDTH  (FLIT_WIDTH),
      .MAX_PKT_LEN (MAX_PKT_LEN),
      .LEN_BITS    (LEN_BITS)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .flit_valid (slot_valid_s[v]),
      .flit_type  (in_type_s),
      .flit_data  (in_link_i),
      .accept     (slot_accept_s[v]),
      .ready      (vc_ready_s[v]),
      .count      (vc_count_s[v]),
      .slots      (vc_slots_s[v]),
      .err_pulse  (vc_err_s[v])
    );
  end

  // Arbitration: a locked offer holds, otherwise first READY VC from rr_ptr.
  always_comb begin
    found_s = 1'b0;
    sel_s   = {VC_BITS{1'b0}};
    if (lock_r) begin
      found_s = 1'b1;
      sel_s   = lock_vc_r;
    end else begin
      for (int k = N_VC - 1; k >= 0; k--) begin
        for (int v = 0; v < N_VC; v++) begin
          if (vc_ready_s[v] && (v == (int'(rr_ptr_r) + k) % N_VC)) begin
            found_s = 1'b1;
            sel_s   = VC_BITS'(v);
          end else begin
            found_s = found_s;
          end
        end
      end
    end
  end

  assign accept_s   = found_s && out_ready_i;
  assign next_ptr_s = (sel_s == VC_BITS'(N_VC - 1)) ? {VC_BITS{1'b0}} : sel_s + VC_BITS'(1);

  // Per-VC flit steering and accept decode.
  always_comb begin
    slot_valid_s  = {N_VC{1'b0}};
    slot_accept_s = {N_VC{1'b0}};
    for (int v = 0; v < N_VC; v++) begin
      if (in_valid_i && vc_ok_s && (in_vc_i == VC_BITS'(v))) begin
        slot_valid_s[v] = 1'b1;
      end else begin
        slot_valid_s[v] = 1'b0;
      end
      if (accept_s && (sel_s == VC_BITS'(v))) begin
        slot_accept_s[v] = 1'b1;
      end else begin
        slot_accept_s[v] = 1'b0;
      end
    end
  end

  // Output mux, forced to zero when nothing is offered.
  always_comb begin
    out_len_s  = {LEN_BITS{1'b0}};
    out_link_s = '0;
    for (int v = 0; v < N_VC; v++) begin
      if (found_s && (sel_s == VC_BITS'(v))) begin
        out_len_s  = vc_count_s[v];
        out_link_s = vc_slots_s[v];
      end else begin
        out_len_s = out_len_s;
      end
    end
  end

  // Round-robin pointer and offer lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r  <= {VC_BITS{1'b0}};
      lock_r    <= 1'b0;
      lock_vc_r <= {VC_BITS{1'b0}};
    end else if (accept_s) begin
      rr_ptr_r  <= next_ptr_s;
      lock_r    <= 1'b0;
      lock_vc_r <= {VC_BITS{1'b0}};
    end else if (found_s) begin
      lock_r    <= 1'b1;
      lock_vc_r <= sel_s;
    end else begin
      lock_r    <= lock_r;
    end
  end

  // Sticky protocol error, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | (|vc_err_s) | (in_valid_i & ~vc_ok_s);
    end
  end

  // Reset suppresses credit/free: nothing is consumed or released that cycle.
  assign credit_o    = rst ? {N_VC{1'b0}} : slot_valid_s;
  assign free_o      = rst ? {N_VC{1'b0}} : slot_accept_s;
  assign out_valid_o = found_s;
  assign out_vc_o    = sel_s;
  assign out_len_o   = out_len_s;
  assign out_link_o  = out_link_s;
  assign err_o       = err_r;

endmodule

// File: tb/tb_nic_vc_flits_buffer.sv
// Bench for nic_vc_flits_buffer: vector table, corner sequences, random vs. model.
module tb_nic_vc_flits_buffer;

  localparam int FW   = 32;
  localparam int NVC  = 2;
  localparam int MAXL = 4;
  localparam int VCB  = 1;
  localparam int LB   = 3;
  localparam int LW   = MAXL * FW;

  logic            clk = 1'b0;
  logic            rst;
  logic [FW-1:0]   in_link_i;
  logic            in_valid_i;
  logic [VCB-1:0]  in_vc_i;
  logic [NVC-1:0]  credit_o;
  logic [NVC-1:0]  free_o;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [VCB-1:0]  out_vc_o;
  logic [LB-1:0]   out_len_o;
  logic [LW-1:0]   out_link_o;
  logic            err_o;

  always #5 clk = ~clk;

  nic_vc_flits_buffer #(.FLIT_WIDTH(FW), .N_VC(NVC), .MAX_PKT_LEN(MAXL)) dut (
    .clk(clk), .rst(rst), .in_link_i(in_link_i), .in_valid_i(in_valid_i),
    .in_vc_i(in_vc_i), .credit_o(credit_o), .free_o(free_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_vc_o(out_vc_o),
    .out_len_o(out_len_o), .out_link_o(out_link_o), .err_o(err_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: per-VC packet buffers plus arbitration bookkeeping.
  logic [FW-1:0] mbuf [NVC][MAXL];
  int  mlen [NVC];
  bit  mrdy [NVC];
  int  mrr;
  bit  mlock;
  int  mlock_vc;
  bit  merr;
  bit  mknown = 1'b0;

  function automatic int m_sel();
    if (mlock) return mlock_vc;
    for (int k = 0; k < NVC; k++) begin
      if (mrdy[(mrr + k) % NVC]) return (mrr + k) % NVC;
    end
    return -1;
  endfunction

  task automatic m_update(input bit r, input bit v, input int vc, input logic [FW-1:0] f,
                          input bit rdy, input int s);
    logic [1:0] t;
    if (r) begin
      for (int i = 0; i < NVC; i++) begin
        mlen[i] = 0;
        mrdy[i] = 1'b0;
      end
      mrr = 0; mlock = 1'b0; mlock_vc = 0; merr = 1'b0; mknown = 1'b1;
      return;
    end
    t = f[FW-1:FW-2];
    if (v) begin
      if (mrdy[vc]) begin
        merr = 1'b1;
      end else if (mlen[vc] == 0) begin
        if (t == 2'b00 || t == 2'b11) begin
          mbuf[vc][0] = f;
          mlen[vc] = 1;
          mrdy[vc] = (t == 2'b11);
        end else begin
          merr = 1'b1;
        end
      end else if (t == 2'b01 && mlen[vc] < MAXL - 1) begin
        mbuf[vc][mlen[vc]] = f;
        mlen[vc]++;
      end else if (t == 2'b10) begin
        mbuf[vc][mlen[vc]] = f;
        mlen[vc]++;
        mrdy[vc] = 1'b1;
      end else begin
        merr = 1'b1;
        mlen[vc] = 0;
      end
    end
    if (s >= 0 && rdy) begin
      mrdy[s] = 1'b0; mlen[s] = 0; mrr = (s + 1) % NVC; mlock = 1'b0;
    end else if (s >= 0) begin
      mlock = 1'b1; mlock_vc = s;
    end
  endtask

  logic [NVC-1:0] smp_credit, smp_free;
  logic           smp_valid, smp_err;
  logic [VCB-1:0] smp_vc;
  logic [LB-1:0]  smp_len;
  logic [LW-1:0]  smp_link;

  // One clock: drive, sample at negedge, compare with model, advance model.
  task automatic cycle(input bit r, input bit v, input int vc, input logic [FW-1:0] f, input bit rdy);
    int s;
    logic [NVC-1:0] ecr, efr;
    logic [LW-1:0]  elink;
    rst = r; in_valid_i = v; in_vc_i = vc[VCB-1:0]; in_link_i = f; out_ready_i = rdy;
    @(negedge clk);
    smp_credit = credit_o; smp_free = free_o; smp_valid = out_valid_o; smp_err = err_o;
    smp_vc = out_vc_o; smp_len = out_len_o; smp_link = out_link_o;
    s = mknown ? m_sel() : -1;
    ecr = (!r && v) ? NVC'(1 << vc) : '0;
    efr = (!r && s >= 0 && rdy) ? NVC'(1 << s) : '0;
    chk("m_credit", LW'(smp_credit), LW'(ecr));
    chk("m_free", LW'(smp_free), LW'(efr));
    if (!r && mknown) begin
      elink = '0;
      if (s >= 0) begin
        for (int i = 0; i < mlen[s]; i++) elink[i*FW +: FW] = mbuf[s][i];
      end
      chk("m_valid", LW'(smp_valid), LW'(s >= 0));
      chk("m_vc", LW'(smp_vc), (s >= 0) ? LW'(s) : '0);
      chk("m_len", LW'(smp_len), (s >= 0) ? LW'(mlen[s]) : '0);
      chk("m_link", smp_link, elink);
      chk("m_err", LW'(smp_err), LW'(merr));
    end
    @(posedge clk);
    m_update(r, v, vc, f, rdy, s);
    #1;
  endtask

  typedef struct {
    bit r; bit v; int vc; logic [FW-1:0] f; bit rdy;
    logic [NVC-1:0] cr; logic [NVC-1:0] fr; bit val; logic [VCB-1:0] vo; logic [LB-1:0] len; bit err;
  } vec_t;

  vec_t tbl [15];
  logic [1:0] rt;
  logic [29:0] rd;

  initial begin
    rst = 1'b1; in_valid_i = 1'b0; in_vc_i = '0; in_link_i = '0; out_ready_i = 1'b0;

    tbl[0]  = '{1'b1, 1'b0, 0, 32'h0000_0000, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 0, 32'h0000_0000, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 0, 32'hC000_00AA, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 0, 32'h0000_0000, 1'b1, 2'b00, 2'b01, 1'b1, 1'b0, 3'd1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 0, 32'h0000_0000, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 0, 32'h0000_0000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 0, 32'h0000_0001, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1, 32'h0000_0011, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 0, 32'h4000_0002, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 0, 32'h8000_0003, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1, 32'h8000_0012, 1'b0, 2'b10, 2'b00, 1'b1, 1'b0, 3'd3, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 0, 32'h0000_0000, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 3'd3, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 0, 32'h0000_0000, 1'b1, 2'b00, 2'b01, 1'b1, 1'b0, 3'd3, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 0, 32'h0000_0000, 1'b1, 2'b00, 2'b10, 1'b1, 1'b1, 3'd2, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 0, 32'h0000_0000, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0};

    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].r, tbl[i].v, tbl[i].vc, tbl[i].f, tbl[i].rdy);
      chk($sformatf("vec%0d_credit", i), LW'(smp_credit), LW'(tbl[i].cr));
      chk($sformatf("vec%0d_free", i), LW'(smp_free), LW'(tbl[i].fr));
      if (!tbl[i].r) begin
        chk($sformatf("vec%0d_valid", i), LW'(smp_valid), LW'(tbl[i].val));
        chk($sformatf("vec%0d_vc", i), LW'(smp_vc), LW'(tbl[i].vo));
        chk($sformatf("vec%0d_len", i), LW'(smp_len), LW'(tbl[i].len));
        chk($sformatf("vec%0d_err", i), LW'(smp_err), LW'(tbl[i].err));
      end
    end

    // Backpressure: VC0 offer held for five cycles while VC1 completes.
    cycle(1'b1, 1'b0, 0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 0, 32'hC000_0055, 1'b0);
    cycle(1'b0, 1'b1, 1, 32'h0000_0021, 1'b0);
    chk("bp_vc", LW'(smp_vc), LW'(0));
    chk("bp_link", smp_link, LW'(32'hC000_0055));
    cycle(1'b0, 1'b1, 1, 32'h8000_0022, 1'b0);
    chk("bp_vc", LW'(smp_vc), LW'(0));
    chk("bp_link", smp_link, LW'(32'hC000_0055));
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 0, 32'h0, 1'b0);
      chk("bp_hold_vc", LW'(smp_vc), LW'(0));
      chk("bp_hold_link", smp_link, LW'(32'hC000_0055));
    end
    cycle(1'b0, 1'b0, 0, 32'h0, 1'b1);
    chk("bp_acc_free", LW'(smp_free), LW'(2'b01));
    cycle(1'b0, 1'b0, 0, 32'h0, 1'b1);
    chk("bp_next_vc", LW'(smp_vc), LW'(1));
    chk("bp_next_len", LW'(smp_len), LW'(2));

    // Overflow: HEAD plus three BODY flits on a four-slot VC.
    cycle(1'b1, 1'b0, 0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 0, 32'h0000_0031, 1'b0);
    cycle(1'b0, 1'b1, 0, 32'h4000_0032, 1'b0);
    cycle(1'b0, 1'b1, 0, 32'h4000_0033, 1'b0);
    cycle(1'b0, 1'b1, 0, 32'h4000_0034, 1'b0);
    chk("ovf_credit", LW'(smp_credit), LW'(2'b01));
    chk("ovf_err_before", LW'(smp_err), LW'(0));
    cycle(1'b0, 1'b0, 0, 32'h0, 1'b0);
    chk("ovf_err", LW'(smp_err), LW'(1));
    chk("ovf_valid", LW'(smp_valid), LW'(0));
    cycle(1'b0, 1'b1, 0, 32'hC000_0035, 1'b1);
    cycle(1'b0, 1'b0, 0, 32'h0, 1'b1);
    chk("ovf_idle_len", LW'(smp_len), LW'(1));

    // Protocol errors: BODY on IDLE, then HEAD on a READY VC.
    cycle(1'b1, 1'b0, 0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 0, 32'h4000_0041, 1'b0);
    cycle(1'b0, 1'b0, 0, 32'h0, 1'b0);
    chk("perr_body_err", LW'(smp_err), LW'(1));
    chk("perr_body_valid", LW'(smp_valid), LW'(0));
    cycle(1'b1, 1'b0, 0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 1, 32'hC000_0077, 1'b0);
    cycle(1'b0, 1'b1, 1, 32'h0000_0078, 1'b0);
    chk("perr_head_credit", LW'(smp_credit), LW'(2'b10));
    cycle(1'b0, 1'b0, 0, 32'h0, 1'b0);
    chk("perr_head_err", LW'(smp_err), LW'(1));
    chk("perr_head_link", smp_link, LW'(32'hC000_0077));

    // Reset mid-packet and mid-offer, then a fresh packet.
    cycle(1'b0, 1'b1, 0, 32'h0000_0081, 1'b0);
    cycle(1'b0, 1'b1, 0, 32'h4000_0082, 1'b0);
    cycle(1'b1, 1'b0, 0, 32'h0, 1'b1);
    chk("rst_free", LW'(smp_free), LW'(0));
    cycle(1'b0, 1'b0, 0, 32'h0, 1'b0);
    chk("rst_valid", LW'(smp_valid), LW'(0));
    chk("rst_err", LW'(smp_err), LW'(0));
    chk("rst_link", smp_link, LW'(0));
    cycle(1'b0, 1'b1, 0, 32'hC000_0099, 1'b1);
    cycle(1'b0, 1'b0, 0, 32'h0, 1'b1);
    chk("rst_fresh_len", LW'(smp_len), LW'(1));
    chk("rst_fresh_link", smp_link, LW'(32'hC000_0099));

    // Random traffic against the model.
    for (int n = 0; n < 800; n++) begin
      rt = 2'($urandom_range(0, 3));
      rd = 30'($urandom);
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, int'($urandom_range(0, 1)),
            {rt, rd}, $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
